ghost_catch_ctrl: RTL
=====================

# ghost_catch_ctrl

Downstream consumer of the ghost mover's position outputs. Compares each ghost position against Pacman's position once per movement tick and debounces overlaps into a catch event. Tracks remaining lives and sequences play, death-freeze, respawn and game-over. Drives the freeze and respawn controls that gate the ghost and Pacman movers.

## Interface
- HIT_DIST, 8: overlap window in pixels, per axis (strict less-than).
- HOLD_TICKS, 2: consecutive overlapping ticks required to declare a catch; range 1..7.
- LIVES, 3: lives loaded on game start; range 1..3.
- RESPAWN_TICKS, 120: ticks spent frozen after a catch; range 1..1023.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle strobe per movement step; sampling only happens on tick.
- start  in  1  one-cycle start/restart request.
- pac_x  in  10  Pacman X position.
- pac_y  in  9  Pacman Y position.
- ghost_x  in  10  ghost X position.
- ghost_y  in  9  ghost Y position.
- state  out  2  FSM state: IDLE=0, PLAY=1, DYING=2, OVER=3.
- lives  out  2  remaining lives.
- hit  out  1  one-cycle pulse on a catch.
- respawn  out  1  one-cycle pulse; movers reload their start positions.
- freeze  out  1  high means movers hold position.
- game_over  out  1  high in OVER.

## Operation
- Reset values: state=IDLE, lives=LIVES, hit=0, respawn=0, freeze=1, game_over=0, overlap counter=0, timer=0.
- Overlap test:
  - dx = |pac_x − ghost_x|, computed as an 11-bit signed difference followed by abs.
  - dy = |pac_y − ghost_y|, computed as a 10-bit signed difference followed by abs.
  - overlap = (dx < HIT_DIST) && (dy < HIT_DIST).
  - No wrap-around: positions are treated as unsigned and never modulo.
- IDLE:
  - freeze=1.
  - start → PLAY, lives←LIVES, overlap counter←0, freeze←0.
- PLAY:
  - On tick with overlap: counter increments, saturating at HOLD_TICKS.
  - On tick without overlap: counter←0.
  - Ticks are the only sampling points; non-tick cycles leave the counter unchanged.
  - When the sampled tick brings the counter to HOLD_TICKS:
    - hit pulses and lives decrements.
    - If lives was 1: go to OVER with lives=0.
    - Otherwise: go to DYING with timer←RESPAWN_TICKS and freeze←1.
  - start is ignored.
- DYING:
  - freeze=1.
  - Timer decrements on each tick.
  - On the tick where timer==1: timer←0, respawn pulses, counter←0, freeze←0, go to PLAY.
  - Overlap is not sampled and start is ignored.
- OVER:
  - freeze=1, game_over=1.
  - start → PLAY with lives←LIVES, counter←0, game_over←0, freeze←0.
- Simultaneous events:
  - start and tick in the same cycle in IDLE or OVER: the transition wins and the tick is not sampled.
  - A tick that completes the catch also produces hit in that same transition; there is no double decrement.
- Reset mid-operation (any state, any timer value): immediate return to reset values; any pending pulse is dropped.

## Timing
- All outputs are registered.
- hit, respawn and every state change appear on the clk edge following the qualifying input cycle.
- Catch latency: hit is high in the cycle after the HOLD_TICKS-th consecutive overlapping tick.
- hit and respawn are exactly one clk cycle wide and never assert together.
- freeze rises in the same cycle as hit.
- freeze falls in the same cycle as respawn, or one cycle after start.
- DYING lasts exactly RESPAWN_TICKS ticks.

## Structure
- Shared package ghost_pkg holds:
  - the state encoding (IDLE/PLAY/DYING/OVER);
  - position widths (X 10 bits, Y 9 bits);
  - the direction encoding shared with the movers.
- Sub-module hit_box_cmp: purely combinational abs-difference window compare producing overlap; reusable for pellet and other-ghost checks.
- Timer width: clog2(RESPAWN_TICKS+1). Counter width: 3 bits.

## Test plan
- Basic catch:
  - Stimulus: start; pac=(200,146), ghost=(205,150); two ticks.
  - Required: hit one cycle after the 2nd tick; lives 3→2; state=DYING; freeze=1.
- Respawn timing (RESPAWN_TICKS=4):
  - Stimulus: after a catch, issue 4 ticks.
  - Required: respawn pulse after the 4th tick; state=PLAY; freeze=0; counter=0.
- Debounce and window edges:
  - Stimulus: overlap, miss, overlap with dx=7; then dx=8.
  - Required: no hit, counter reset by the miss; dx=8 never counts as overlap.
- Game over:
  - Stimulus: three catches.
  - Required: lives=0, state=OVER, game_over=1; further ticks change nothing.
  - Stimulus: start.
  - Required: lives=3, state=PLAY.
- Signed-difference and reset:
  - Stimulus: pac=(3,2), ghost=(1000,500).
  - Required: no overlap.
  - Stimulus: assert rst mid-DYING with timer=50.
  - Required: immediately IDLE, lives=3, freeze=1, no respawn pulse.

Source files
------------

// File: rtl/ghost_pkg.sv
// ghost_pkg: definitions shared by the ghost mover, the Pacman mover and the
// catch controller.
//   state_t  - catch controller FSM encoding (IDLE/PLAY/DYING/OVER)
//   X_W/Y_W  - playfield position widths
//   dir_t    - movement direction encoding used by the movers
package ghost_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

endpackage

// File: rtl/hit_box_cmp.sv
// hit_box_cmp: purely combinational window compare between two points.
// overlap is high when |ax-bx| < HIT_DIST and |ay-by| < HIT_DIST.
// Positions are unsigned; the differences are taken one bit wider as signed
// values so that no wrap-around can occur.
//   ax, bx   in  X_W  X positions
//   ay, by   in  Y_W  Y positions
//   overlap  out 1    both axis distances inside the window
module hit_box_cmp
  import ghost_pkg::*;
#(
  parameter int unsigned HIT_DIST = 8
) (
  input  logic [X_W-1:0] ax,
  input  logic [Y_W-1:0] ay,
  input  logic [X_W-1:0] bx,
  input  logic [Y_W-1:0] by,
  output logic           overlap
);

  localparam logic [X_W:0] HIT_X = (X_W+1)'(HIT_DIST);
  localparam logic [Y_W:0] HIT_Y = (Y_W+1)'(HIT_DIST);

  logic signed [X_W:0] diff_x;
  logic signed [Y_W:0] diff_y;
  logic        [X_W:0] abs_x;
  logic        [Y_W:0] abs_y;

  // NOTE: combinational blocks use blocking '=' and assign every output on
  // every path, so no latch can be inferred.
  always_comb begin
    diff_x  = $signed({1'b0, ax}) - $signed({1'b0, bx});
    diff_y  = $signed({1'b0, ay}) - $signed({1'b0, by});
    // Magnitudes never exceed 2^X_W-1 / 2^Y_W-1, so negation cannot overflow.
    abs_x   = $unsigned(diff_x < 0 ? -diff_x : diff_x);
    abs_y   = $unsigned(diff_y < 0 ? -diff_y : diff_y);
    overlap = (abs_x < HIT_X) && (abs_y < HIT_Y);
  end

endmodule

// File: rtl/ghost_catch_ctrl.sv
// ghost_catch_ctrl: debounces ghost/Pacman overlaps into catch events and
// sequences play, death-freeze, respawn and game-over.
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-low reset
//   tick       in   1   movement step strobe; the only sampling point
//   start      in   1   start / restart request (honoured in IDLE and OVER)
//   pac_x/y    in   10/9 Pacman position
//   ghost_x/y  in   10/9 ghost position
//   state      out  2   IDLE=0, PLAY=1, DYING=2, OVER=3
//   lives      out  2   remaining lives
//   hit        out  1   one-cycle pulse on a catch
//   respawn    out  1   one-cycle pulse, movers reload start positions
//   freeze     out  1   movers hold position while high
//   game_over  out  1   high in OVER
module ghost_catch_ctrl
  import ghost_pkg::*;
#(
  parameter int unsigned HIT_DIST      = 8,
  parameter int unsigned HOLD_TICKS    = 2,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned RESPAWN_TICKS = 120
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           start,
  input  logic [X_W-1:0] pac_x,
  input  logic [Y_W-1:0] pac_y,
  input  logic [X_W-1:0] ghost_x,
  input  logic [Y_W-1:0] ghost_y,
  output logic [1:0]     state,
  output logic [1:0]     lives,
  output logic           hit,
  output logic           respawn,
  output logic           freeze,
  output logic           game_over
);

  localparam int unsigned      TIMER_W    = $clog2(RESPAWN_TICKS + 1);
  localparam logic [2:0]       HOLD       = 3'(HOLD_TICKS);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(RESPAWN_TICKS);

  state_t             state_q;
  logic [2:0]         cnt;
  logic [2:0]         cnt_inc;
  logic [TIMER_W-1:0] timer;
  logic               overlap;

  hit_box_cmp #(
    .HIT_DIST(HIT_DIST)
  ) u_hit_box (
    .ax     (pac_x),
    .ay     (pac_y),
    .bx     (ghost_x),
    .by     (ghost_y),
    .overlap(overlap)
  );

  // Saturating increment of the consecutive-overlap counter.
  assign cnt_inc = (cnt >= HOLD) ? HOLD : cnt + 3'd1;
  assign state   = state_q;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lives     <= LIVES_INIT;
      hit       <= 1'b0;
      respawn   <= 1'b0;
      freeze    <= 1'b1;
      game_over <= 1'b0;
      cnt       <= 3'd0;
      timer     <= '0;
    end else begin
      // Pulses default low; at most one branch below raises one of them.
      hit     <= 1'b0;
      respawn <= 1'b0;

      case (state_q)
        IDLE: begin
          freeze <= 1'b1;
          if (start) begin
            state_q <= PLAY;
            lives   <= LIVES_INIT;
            cnt     <= 3'd0;
            freeze  <= 1'b0;
          end
        end

        PLAY: begin
          if (tick) begin
            if (!overlap) begin
              cnt <= 3'd0;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == HOLD) begin
                hit   <= 1'b1;
                lives <= lives - 2'd1;
                freeze <= 1'b1;
                if (lives == 2'd1) begin
                  state_q   <= OVER;
                  game_over <= 1'b1;
                end else begin
                  state_q <= DYING;
                  timer   <= TIMER_INIT;
                end
              end
            end
          end
        end

        DYING: begin
          freeze <= 1'b1;
          if (tick) begin
            if (timer == TIMER_W'(1)) begin
              timer   <= '0;
              respawn <= 1'b1;
              cnt     <= 3'd0;
              freeze  <= 1'b0;
              state_q <= PLAY;
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
        end

        OVER: begin
          freeze    <= 1'b1;
          game_over <= 1'b1;
          if (start) begin
            state_q   <= PLAY;
            lives     <= LIVES_INIT;
            cnt       <= 3'd0;
            game_over <= 1'b0;
            freeze    <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
